dist_sprite_motion_ctrl: RTL

//  Per-frame motion sequencer for the distance-sprite compositor. Detects the v_sync

---
 rtl/dist_pkg.sv | 30 +++
 rtl/dist_sprite_motion_ctrl_if.sv | 36 +++
 rtl/dist_axis_step.sv | 51 +++++
 rtl/dist_sprite_motion_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// rtl/dist_pkg.sv - shared types and screen/sprite geometry for the distance-sprite path
// Purpose: motion FSM state encoding, coordinate type, screen and sprite sizes,
//          bounce limits and a clamp helper. Imported by the motion controller,
//          its axis stepper and the compositor.
// Ports:   none (package)
package dist_pkg;

  typedef logic [15:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP_X = 2'd1,
    ST_STEP_Y = 2'd2,
    ST_COMMIT = 2'd3
  } motion_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 256;  // 32 texels x 8
  localparam int SPRITE_H = 64;   // 8 texels x 8

  // Largest top-left coordinate that keeps the whole sprite on screen.
  localparam coord_t X_MAX = coord_t'(SCREEN_W - SPRITE_W);
  localparam coord_t Y_MAX = coord_t'(SCREEN_H - SPRITE_H);

  function automatic coord_t clamp_coord(input coord_t i_val, input coord_t i_lim);
    return (i_val > i_lim) ? i_lim : i_val;
  endfunction

endpackage

// File: rtl/dist_sprite_motion_ctrl_if.sv
// rtl/dist_sprite_motion_ctrl_if.sv - control/position bundle between host, motion controller and compositor
// Purpose: groups the v_sync/enable/load inputs and the committed position,
//          flip, update, bounce and overrun outputs of the motion controller.
// Ports (signals):
//   i_v_sync, i_enable, i_load, i_load_x[15:0], i_load_y[15:0]   host -> controller
//   o_sprite_x[15:0], o_sprite_y[15:0], o_x_flip, o_y_flip,
//   o_update, o_bounce_cnt[7:0], o_overrun                      controller -> compositor/host
// Modports: master = motion controller, slave = host/compositor side.
interface dist_sprite_motion_ctrl_if;
  import dist_pkg::*;

  logic       i_v_sync;
  logic       i_enable;
  logic       i_load;
  coord_t     i_load_x;
  coord_t     i_load_y;

  coord_t     o_sprite_x;
  coord_t     o_sprite_y;
  logic       o_x_flip;
  logic       o_y_flip;
  logic       o_update;
  logic [7:0] o_bounce_cnt;
  logic       o_overrun;

  modport master (
    input  i_v_sync, i_enable, i_load, i_load_x, i_load_y,
    output o_sprite_x, o_sprite_y, o_x_flip, o_y_flip, o_update, o_bounce_cnt, o_overrun
  );

  modport slave (
    output i_v_sync, i_enable, i_load, i_load_x, i_load_y,
    input  o_sprite_x, o_sprite_y, o_x_flip, o_y_flip, o_update, o_bounce_cnt, o_overrun
  );

endinterface

// File: rtl/dist_axis_step.sv
// rtl/dist_axis_step.sv - one-axis position step with wall bounce (combinational)
// Purpose: advances a coordinate by i_step in the direction i_dir, clamping to
//          0 or i_max and reversing direction when a wall is reached.
// Ports:
//   i_pos[15:0]      current position
//   i_dir            1 = increasing (right/down), 0 = decreasing
//   i_step[15:0]     pixels per update
//   i_max[15:0]      largest legal position
//   o_next_pos[15:0] stepped position
//   o_next_dir       direction after the step
//   o_hit            1 when this step reached a wall
module dist_axis_step
  import dist_pkg::*;
(
  input  coord_t i_pos,
  input  logic   i_dir,
  input  coord_t i_step,
  input  coord_t i_max,
  output coord_t o_next_pos,
  output logic   o_next_dir,
  output logic   o_hit
);

  // 17-bit sum so a position near 0xFFFF cannot wrap past the wall test.
  logic [16:0] w_sum;
  assign w_sum = {1'b0, i_pos} + {1'b0, i_step};

  always_comb begin
    o_next_pos = i_pos;
    o_next_dir = i_dir;
    o_hit      = 1'b0;
    if (i_dir) begin
      if (w_sum >= {1'b0, i_max}) begin
        o_next_pos = i_max;
        o_next_dir = 1'b0;
        o_hit      = 1'b1;
      end else begin
        o_next_pos = w_sum[15:0];
      end
    end else begin
      if (i_pos <= i_step) begin
        o_next_pos = '0;
        o_next_dir = 1'b1;
        o_hit      = 1'b1;
      end else begin
        o_next_pos = i_pos - i_step;
      end
    end
  end

endmodule

// File: rtl/dist_sprite_motion_ctrl.sv
// rtl/dist_sprite_motion_ctrl.sv - per-frame sprite motion sequencer with edge bounce
// Purpose: synchronises v_sync, divides frames, steps the sprite one axis per
//          cycle into shadow registers and commits position/flip/bounce to the
//          compositor once per frame with a one-cycle o_update pulse.
// Ports:
//   i_clk    pixel clock
//   i_rst_n  asynchronous active-low reset
//   bus      dist_sprite_motion_ctrl_if.master (v_sync, enable, load request,
//            committed position/flips, update pulse, bounce count, overrun flag)
module dist_sprite_motion_ctrl
  import dist_pkg::*;
#(
  parameter int unsigned STEP_X    = 2,
  parameter int unsigned STEP_Y    = 1,
  parameter int unsigned INIT_X    = 350,
  parameter int unsigned INIT_Y    = 16,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  dist_sprite_motion_ctrl_if.master bus
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  // v_sync synchroniser and edge detect
  logic             r_vs_meta;
  logic             r_vs_sync;
  logic             r_vs_prev;
  logic             r_vs_edge;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_overrun;

  // FSM
  motion_state_t    r_state;
  motion_state_t    w_state_nxt;
  logic             w_take_load;
  logic             w_due;
  logic             w_busy;

  // shadow (working) motion state
  coord_t           r_sh_x;
  coord_t           r_sh_y;
  logic             r_dir_x;
  logic             r_dir_y;
  logic             r_flip_x;
  logic             r_flip_y;
  logic [7:0]       r_sh_bounce;

  // committed outputs
  coord_t           r_out_x;
  coord_t           r_out_y;
  logic             r_out_flip_x;
  logic             r_out_flip_y;
  logic [7:0]       r_out_bounce;

  // axis stepper results
  coord_t           w_x_next;
  logic             w_dir_x_next;
  logic             w_hit_x;
  coord_t           w_y_next;
  logic             w_dir_y_next;
  logic             w_hit_y;
  logic [7:0]       w_bounce_y;
  coord_t           w_load_x;
  coord_t           w_load_y;

  assign w_due      = r_vs_edge && (r_div_cnt == DIV_LAST);
  assign w_busy     = (r_state != ST_IDLE);
  assign w_bounce_y = r_sh_bounce + {7'd0, w_hit_y};
  assign w_load_x   = clamp_coord(bus.i_load_x, X_MAX);
  assign w_load_y   = clamp_coord(bus.i_load_y, Y_MAX);

  dist_axis_step u_step_x (
    .i_pos      (r_sh_x),
    .i_dir      (r_dir_x),
    .i_step     (coord_t'(STEP_X)),
    .i_max      (X_MAX),
    .o_next_pos (w_x_next),
    .o_next_dir (w_dir_x_next),
    .o_hit      (w_hit_x)
  );

  dist_axis_step u_step_y (
    .i_pos      (r_sh_y),
    .i_dir      (r_dir_y),
    .i_step     (coord_t'(STEP_Y)),
    .i_max      (Y_MAX),
    .o_next_pos (w_y_next),
    .o_next_dir (w_dir_y_next),
    .o_hit      (w_hit_y)
  );

  // Two-flop synchroniser plus registered edge: r_vs_edge is a single-cycle
  // pulse three clocks after the raw input rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
      r_vs_edge <= 1'b0;
      r_div_cnt <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_vs_meta <= bus.i_v_sync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_vs_edge <= r_vs_sync & ~r_vs_prev;
      // The divider runs on every edge, including disabled or busy frames.
      if (r_vs_edge) begin
        r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
      end
      if (r_vs_edge && w_busy) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Load has priority over a due frame; both are only accepted in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_take_load = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.i_load) begin
          w_take_load = 1'b1;
          w_state_nxt = ST_COMMIT;
        end else if (w_due && bus.i_enable) begin
          w_state_nxt = ST_STEP_X;
        end
      end
      ST_STEP_X: w_state_nxt = ST_STEP_Y;
      ST_STEP_Y: w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // The commit registers load on the edge that enters COMMIT, so the new
  // coordinates appear in the same cycle as o_update. In IDLE the shadow and
  // committed copies are always equal.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_x       <= coord_t'(INIT_X);
      r_sh_y       <= coord_t'(INIT_Y);
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_flip_x     <= 1'b0;
      r_flip_y     <= 1'b0;
      r_sh_bounce  <= 8'd0;
      r_out_x      <= coord_t'(INIT_X);
      r_out_y      <= coord_t'(INIT_Y);
      r_out_flip_x <= 1'b0;
      r_out_flip_y <= 1'b0;
      r_out_bounce <= 8'd0;
    end else if (w_take_load) begin
      r_sh_x  <= w_load_x;
      r_sh_y  <= w_load_y;
      r_out_x <= w_load_x;
      r_out_y <= w_load_y;
    end else if (r_state == ST_STEP_X) begin
      r_sh_x      <= w_x_next;
      r_dir_x     <= w_dir_x_next;
      r_flip_x    <= r_flip_x ^ w_hit_x;
      r_sh_bounce <= r_sh_bounce + {7'd0, w_hit_x};
    end else if (r_state == ST_STEP_Y) begin
      r_sh_y       <= w_y_next;
      r_dir_y      <= w_dir_y_next;
      r_flip_y     <= r_flip_y ^ w_hit_y;
      r_sh_bounce  <= w_bounce_y;
      r_out_x      <= r_sh_x;
      r_out_y      <= w_y_next;
      r_out_flip_x <= r_flip_x;
      r_out_flip_y <= r_flip_y ^ w_hit_y;
      r_out_bounce <= w_bounce_y;
    end
  end

  assign bus.o_sprite_x   = r_out_x;
  assign bus.o_sprite_y   = r_out_y;
  assign bus.o_x_flip     = r_out_flip_x;
  assign bus.o_y_flip     = r_out_flip_y;
  assign bus.o_update     = (r_state == ST_COMMIT);
  assign bus.o_bounce_cnt = r_out_bounce;
  assign bus.o_overrun    = r_overrun;

endmodule
